// File: rtl/exp_controller.sv
// exp_controller -- control FSM for the series-evaluation datapath
//   distance = v * sum_k (x^2)^k * coef_k
// Sequences the datapath through INIT, then ACC / MUL_POW / MUL_ROM per term,
// and finishes with FINAL, which loads distance and sets the done flag.
//
// Parameters
//   TERM_LIMIT  maximum number of series terms accumulated (1..8)
// Optional feature
//   EXP_CTRL_ABORT_EN  adds the abort input. An abort cycle outside IDLE
//                      clears done, performs no load and returns to IDLE.
// Ports
//   clk, asyncRst        clock, synchronous active-high reset
//   start                run request, sampled in IDLE only
//   c                    datapath counter terminal flag (count == 7)
//   abort                cancel (EXP_CTRL_ABORT_EN only)
//   busy                 high in every state except IDLE
//   s_done, r_done       set / clear datapath done register
//   inc_counter, r_counter  counter increment / clear
//   load_pow             pow <- mult
//   select_mult          0 x*x, 1 rom*term, 2 pow*term, 3 exp*v
//   reset_to_one_term, load_term  term <- 1 / term <- mult
//   load_exp, r_exp      exp <- exp+term / exp <- 0
//   load_distance        distance <- mult
module exp_controller #(
  parameter int TERM_LIMIT = 8
) (
  input  logic       clk,
  input  logic       asyncRst,
  input  logic       start,
  input  logic       c,
`ifdef EXP_CTRL_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic       s_done,
  output logic       r_done,
  output logic       inc_counter,
  output logic       r_counter,
  output logic       load_pow,
  output logic [1:0] select_mult,
  output logic       reset_to_one_term,
  output logic       load_term,
  output logic       load_exp,
  output logic       r_exp,
  output logic       load_distance
);

  localparam logic [3:0] LIM = 4'(TERM_LIMIT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    INIT    = 3'd1,
    ACC     = 3'd2,
    MUL_POW = 3'd3,
    MUL_ROM = 3'd4,
    FINAL   = 3'd5
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] nterm_q, nterm_d;

  always_ff @(posedge clk) begin
    if (asyncRst) begin
      state_q <= IDLE;
      nterm_q <= 4'd0;
    end else begin
      state_q <= state_d;
      nterm_q <= nterm_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    nterm_d           = nterm_q;
    busy              = 1'b0;
    s_done            = 1'b0;
    r_done            = 1'b0;
    inc_counter       = 1'b0;
    r_counter         = 1'b0;
    load_pow          = 1'b0;
    select_mult       = 2'd0;
    reset_to_one_term = 1'b0;
    load_term         = 1'b0;
    load_exp          = 1'b0;
    r_exp             = 1'b0;
    load_distance     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = INIT;
      end
      INIT: begin
        // pow <- x*x while clearing the accumulators; term starts at 1
        busy              = 1'b1;
        r_done            = 1'b1;
        r_counter         = 1'b1;
        r_exp             = 1'b1;
        reset_to_one_term = 1'b1;
        load_pow          = 1'b1;
        nterm_d           = 4'd0;
        state_d           = ACC;
      end
      ACC: begin
        busy     = 1'b1;
        load_exp = 1'b1;
        nterm_d  = nterm_q + 4'd1;
        // Counter terminal and term limit may coincide: single exit either way.
        if (c || ((nterm_q + 4'd1) == LIM)) state_d = FINAL;
        else                                state_d = MUL_POW;
      end
      MUL_POW: begin
        busy        = 1'b1;
        select_mult = 2'd2;
        load_term   = 1'b1;
        state_d     = MUL_ROM;
      end
      MUL_ROM: begin
        // ROM is addressed by the count before this cycle's increment
        busy        = 1'b1;
        select_mult = 2'd1;
        load_term   = 1'b1;
        inc_counter = 1'b1;
        state_d     = ACC;
      end
      FINAL: begin
        // Always returns to IDLE; a held start re-enters INIT the cycle after.
        busy          = 1'b1;
        select_mult   = 2'd3;
        load_distance = 1'b1;
        s_done        = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
`ifdef EXP_CTRL_ABORT_EN
    if (abort && (state_q != IDLE)) begin
      s_done            = 1'b0;
      inc_counter       = 1'b0;
      r_counter         = 1'b0;
      load_pow          = 1'b0;
      select_mult       = 2'd0;
      reset_to_one_term = 1'b0;
      load_term         = 1'b0;
      load_exp          = 1'b0;
      r_exp             = 1'b0;
      load_distance     = 1'b0;
      busy              = 1'b1;
      r_done            = 1'b1;
      nterm_d           = nterm_q;
      state_d           = IDLE;
    end
`endif
  end

endmodule

// File: tb/tb_exp_controller.sv
module tb_exp_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic asyncRst, start0, start1;
`ifdef EXP_CTRL_ABORT_EN
  logic abort;
`endif

  // datapath stand-ins: counter (drives c) and done register
  logic [2:0] cnt0 = 3'd0, cnt1 = 3'd0;
  logic [1:0] done_m = 2'b00;
  logic c0, c1;
  assign c0 = (cnt0 == 3'd7);
  assign c1 = (cnt1 == 3'd7);

  logic       busy0, s_done0, r_done0, inc0, rcnt0, lpow0, rtot0, lterm0, lexp0, rexp0, ldist0;
  logic       busy1, s_done1, r_done1, inc1, rcnt1, lpow1, rtot1, lterm1, lexp1, rexp1, ldist1;
  logic [1:0] sel0, sel1;

  exp_controller #(.TERM_LIMIT(8)) dut0 (
    .clk(clk), .asyncRst(asyncRst), .start(start0), .c(c0),
`ifdef EXP_CTRL_ABORT_EN
    .abort(abort),
`endif
    .busy(busy0), .s_done(s_done0), .r_done(r_done0), .inc_counter(inc0),
    .r_counter(rcnt0), .load_pow(lpow0), .select_mult(sel0),
    .reset_to_one_term(rtot0), .load_term(lterm0), .load_exp(lexp0),
    .r_exp(rexp0), .load_distance(ldist0));

  exp_controller #(.TERM_LIMIT(1)) dut1 (
    .clk(clk), .asyncRst(asyncRst), .start(start1), .c(c1),
`ifdef EXP_CTRL_ABORT_EN
    .abort(1'b0),
`endif
    .busy(busy1), .s_done(s_done1), .r_done(r_done1), .inc_counter(inc1),
    .r_counter(rcnt1), .load_pow(lpow1), .select_mult(sel1),
    .reset_to_one_term(rtot1), .load_term(lterm1), .load_exp(lexp1),
    .r_exp(rexp1), .load_distance(ldist1));

  always @(posedge clk) begin
    if (rcnt0) cnt0 <= 3'd0; else if (inc0) cnt0 <= cnt0 + 3'd1;
    if (rcnt1) cnt1 <= 3'd0; else if (inc1) cnt1 <= cnt1 + 3'd1;
    if (s_done0) done_m[0] <= 1'b1; else if (r_done0) done_m[0] <= 1'b0;
    if (s_done1) done_m[1] <= 1'b1; else if (r_done1) done_m[1] <= 1'b0;
  end

  // {busy, s_done, r_done, inc, r_cnt, load_pow, sel[1:0], rtot, load_term, load_exp, r_exp, load_dist}
  logic [1:0][12:0] ow;
  assign ow[0] = {busy0, s_done0, r_done0, inc0, rcnt0, lpow0, sel0, rtot0, lterm0, lexp0, rexp0, ldist0};
  assign ow[1] = {busy1, s_done1, r_done1, inc1, rcnt1, lpow1, sel1, rtot1, lterm1, lexp1, rexp1, ldist1};

  // expected state codes: 0 IDLE 1 INIT 2 ACC 3 MUL_POW 4 MUL_ROM 5 FINAL 6 abort cycle
  function automatic logic [12:0] exp_word(input int s);
    case (s)
      1:       return 13'b1_0_1_0_1_1_00_1_0_0_1_0;
      2:       return 13'b1_0_0_0_0_0_00_0_0_1_0_0;
      3:       return 13'b1_0_0_0_0_0_10_0_1_0_0_0;
      4:       return 13'b1_0_0_1_0_0_01_0_1_0_0_0;
      5:       return 13'b1_1_0_0_0_0_11_0_0_0_0_1;
      6:       return 13'b1_0_1_0_0_0_00_0_0_0_0_0;
      default: return 13'b0;
    endcase
  endfunction

  typedef struct { int which; logic [12:0] w; int cyc; } ent_t;
  ent_t sbq[$];
  int   npass = 0, ntot = 0;
  int   cyc_n = 0;
  int   nle[2], ninc[2], nlt[2], nsd[2];
  int   seq[$];

  // monitor: counts pulses every cycle, compares whatever the stimulus queued
  initial begin
    ent_t e;
    for (int i = 0; i < 2; i++) begin nle[i] = 0; ninc[i] = 0; nlt[i] = 0; nsd[i] = 0; end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (ow[i][2] === 1'b1) nle[i]++;
        if (ow[i][9] === 1'b1) ninc[i]++;
        if (ow[i][3] === 1'b1) nlt[i]++;
        if (ow[i][11] === 1'b1) nsd[i]++;
      end
      while (sbq.size() > 0) begin
        e = sbq.pop_front();
        ntot++;
        if (ow[e.which] === e.w) npass++;
        else $display("FAIL outputs dut%0d cycle %0d: got %b expected %b", e.which, e.cyc, ow[e.which], e.w);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int expv);
    ntot++;
    if (act == expv) npass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, expv);
  endtask

  // drive one cycle and queue the expected outputs (-1: no check)
  task automatic cyc(input logic s0, input logic s1, input logic rs, input int e0, input int e1);
    ent_t e;
    start0 = s0; start1 = s1; asyncRst = rs;
    if (e0 >= 0) begin e.which = 0; e.w = exp_word(e0); e.cyc = cyc_n; sbq.push_back(e); end
    if (e1 >= 0) begin e.which = 1; e.w = exp_word(e1); e.cyc = cyc_n; sbq.push_back(e); end
    @(posedge clk); #1;
    cyc_n++;
  endtask

  task automatic fill_seq(input int n);
    seq.delete();
    seq.push_back(1);
    for (int k = 1; k <= n; k++) begin
      seq.push_back(2);
      if (k < n) begin seq.push_back(3); seq.push_back(4); end
    end
    seq.push_back(5);
  endtask

  // play run cycles 1..stop_at; smode 0 start low, 1 held, 2 toggling; rs: reset on last cycle
  task automatic play(input int which, input int smode, input int stop_at, input logic rs);
    logic st;
    for (int i = 0; i < seq.size() && i < stop_at; i++) begin
      st = (smode == 1) ? 1'b1 : (smode == 2) ? logic'(i % 2) : 1'b0;
      if (i == 1) chk("done_cleared_by_init", int'(done_m[which]), 0);
      if (which == 0) cyc(st, 1'b0, rs && (i + 1 == stop_at), seq[i], 0);
      else            cyc(1'b0, st, rs && (i + 1 == stop_at), 0, seq[i]);
    end
  endtask

  int b_le, b_inc, b_lt, b_sd;

  initial begin
    start0 = 0; start1 = 0; asyncRst = 1;
`ifdef EXP_CTRL_ABORT_EN
    abort = 0;
`endif
    @(posedge clk); #1;
    // reset, then idle
    cyc(0, 0, 1, 0, 0);
    repeat (10) cyc(0, 0, 0, 0, 0);

    // default 8-term run, start pulse
    b_le = nle[0]; b_inc = ninc[0]; b_lt = nlt[0]; b_sd = nsd[0];
    fill_seq(8);
    cyc(1, 0, 0, 0, 0);
    play(0, 0, 99, 0);
    chk("done_at_25", int'(done_m[0]), 1);
    cyc(0, 0, 0, 0, 0);
    chk("load_exp_count", nle[0] - b_le, 8);
    chk("inc_counter_count", ninc[0] - b_inc, 7);
    chk("load_term_count", nlt[0] - b_lt, 14);
    chk("s_done_count", nsd[0] - b_sd, 1);

    // TERM_LIMIT=1
    b_le = nle[1]; b_inc = ninc[1]; b_lt = nlt[1];
    fill_seq(1);
    cyc(0, 1, 0, 0, 0);
    play(1, 0, 99, 0);
    chk("tl1_done", int'(done_m[1]), 1);
    cyc(0, 0, 0, 0, 0);
    chk("tl1_load_exp", nle[1] - b_le, 1);
    chk("tl1_inc_counter", ninc[1] - b_inc, 0);
    chk("tl1_load_term", nlt[1] - b_lt, 0);

    // start held across two runs: second INIT the cycle after returning to IDLE
    fill_seq(8);
    cyc(1, 0, 0, 0, 0);
    play(0, 1, 99, 0);
    chk("held_done_set", int'(done_m[0]), 1);
    cyc(1, 0, 0, 0, 0);
    play(0, 1, 99, 0);
    chk("held_done_set2", int'(done_m[0]), 1);
    cyc(0, 0, 0, 0, 0);

    // reset during MUL_ROM at cycle 10
    cyc(1, 0, 0, 0, 0);
    play(0, 0, 10, 1);
    repeat (3) cyc(0, 0, 0, 0, 0);
    // fresh run with start toggling while busy
    cyc(1, 0, 0, 0, 0);
    play(0, 2, 99, 0);
    chk("after_reset_done", int'(done_m[0]), 1);
    cyc(0, 0, 0, 0, 0);

`ifdef EXP_CTRL_ABORT_EN
    // abort at cycle 7
    b_sd = nsd[0]; b_le = nle[0];
    cyc(1, 0, 0, 0, 0);
    play(0, 0, 6, 0);
    abort = 1;
    cyc(0, 0, 0, 6, 0);
    abort = 0;
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("abort_no_s_done", nsd[0] - b_sd, 0);
    chk("abort_load_exp", nle[0] - b_le, 2);
    chk("abort_done_low", int'(done_m[0]), 0);
    // abort alone in IDLE ignored; abort with start in IDLE: start wins
    abort = 1;
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    abort = 0;
    play(0, 0, 99, 0);
    chk("abort_start_done", int'(done_m[0]), 1);
    cyc(0, 0, 0, 0, 0);
`endif

    @(negedge clk); #1;
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
